// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// bus width and the byte-lane expansion used by the write path.
package intc_pkg;

    localparam int RegBus = 32;

    // Register index as decoded from addr[4:2]; 6 and 7 are unmapped.
    typedef enum logic [2:0] {
        IntcPending = 3'd0,
        IntcMask    = 3'd1,
        IntcMode    = 3'd2,
        IntcPol     = 3'd3,
        IntcClaim   = 3'd4,
        IntcRaw     = 3'd5
    } intc_reg_e;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [RegBus-1:0] lane_mask(input logic [3:0] sel);
        lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/intc_if.sv
// Memory-mapped slave bus of the interrupt controller, same signal set
// as the data RAM port on the CPU data bus.
interface intc_if;
    import intc_pkg::*;

    logic              ce;
    logic              we;
    logic [RegBus-1:0] addr;
    logic [3:0]        sel;
    logic [RegBus-1:0] data_i;
    logic [RegBus-1:0] data_o;

    modport master (output ce, we, addr, sel, data_i, input data_o);
    modport slave  (input ce, we, addr, sel, data_i, output data_o);

endinterface

// File: rtl/intc_src.sv
// One interrupt source: synchroniser, polarity, edge history and the
// pending flop with set-over-clear priority and edge/level mode handling.
module intc_src import intc_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic pol,
    input  logic mode,
    input  logic clr,
    output logic pend,
    output logic act
);

    logic synced;
    logic act_d;
    logic pend_q;

    generate
        if (SYNC_STAGES == 2) begin : g_sync
            logic [1:0] sync_q;

            // Two-flop synchroniser bringing the raw source into the clock domain.
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '0;
                else     sync_q <= {sync_q[0], src};
            end

            assign synced = sync_q[1];
        end else begin : g_nosync
            assign synced = src;
        end
    endgenerate

    assign act = synced ^ pol;

    // Edge history always tracks act, so switching to edge mode only sees
    // later transitions; level mode keeps the stored bit at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_d  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            act_d <= act;
            if (!mode)               pend_q <= 1'b0;
            else if (act && !act_d)  pend_q <= 1'b1;
            else if (clr)            pend_q <= 1'b0;
        end
    end

    assign pend = mode ? pend_q : act;

endmodule

// File: rtl/intc.sv
// Interrupt controller top: register file with byte-lane writes, claim
// priority encoder, output routing with registered irq_o, and read mux.
module intc import intc_pkg::*; #(
    parameter int NUM_SRC     = 8,
    parameter int NUM_OUT     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    intc_if.slave              bus,
    output logic [NUM_OUT-1:0] irq_o
);

    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] pol_q;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] eff;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] claim_hot;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] wmask_s;
    logic [NUM_SRC-1:0] wdata_s;
    logic [RegBus-1:0]  wmask;
    logic [RegBus-1:0]  claim_val;
    logic [RegBus-1:0]  eff32;
    logic [RegBus-1:0]  rd_data;
    logic [NUM_OUT-1:0] irq_next;
    logic               wr_en;
    logic               rd_en;
    logic               unused_bits;
    intc_reg_e          reg_sel;

    assign wr_en       = bus.ce & bus.we;
    assign rd_en       = bus.ce & ~bus.we;
    assign reg_sel     = intc_reg_e'(bus.addr[4:2]);
    assign wmask       = lane_mask(bus.sel);
    assign wmask_s     = wmask[NUM_SRC-1:0];
    assign wdata_s     = bus.data_i[NUM_SRC-1:0];
    assign unused_bits = ^{bus.addr, bus.data_i, wmask};

    assign w1c       = (wr_en && reg_sel == IntcPending) ? (wdata_s & wmask_s) : '0;
    assign claim_clr = (rd_en && reg_sel == IntcClaim) ? claim_hot : '0;
    assign clr       = w1c | claim_clr;
    assign eff       = pend & mask_q;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            intc_src #(.SYNC_STAGES(SYNC_STAGES)) u_src (
                .clk  (clk),
                .rst  (rst),
                .src  (src_i[g]),
                .pol  (pol_q[g]),
                .mode (mode_q[g]),
                .clr  (clr[g]),
                .pend (pend[g]),
                .act  (act[g])
            );
        end
    endgenerate

    // Lowest enabled pending source wins the claim; scanning downwards lets
    // the lowest index overwrite higher ones.
    always_comb begin
        claim_val = '0;
        claim_hot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) begin
                claim_val    = RegBus'(i + 1);
                claim_hot    = '0;
                claim_hot[i] = 1'b1;
            end
        end
    end

    // Configuration registers, each byte lane written only when selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            mode_q <= '0;
            pol_q  <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                IntcMask: mask_q <= (mask_q & ~wmask_s) | (wdata_s & wmask_s);
                IntcMode: mode_q <= (mode_q & ~wmask_s) | (wdata_s & wmask_s);
                IntcPol:  pol_q  <= (pol_q  & ~wmask_s) | (wdata_s & wmask_s);
                default: ;
            endcase
        end
    end

    // Route enabled sources to CPU lines; the top line collects the rest.
    always_comb begin
        eff32              = '0;
        eff32[NUM_SRC-1:0] = eff;
        irq_next           = '0;
        for (int k = 0; k < NUM_OUT - 1; k++) begin
            irq_next[k] = eff32[k];
        end
        irq_next[NUM_OUT-1] = |(eff32 >> (NUM_OUT - 1));
    end

    // Registered interrupt lines towards the CPU.
    always_ff @(posedge clk) begin
        if (rst) irq_o <= '0;
        else     irq_o <= irq_next;
    end

    // Same-cycle read data; unmapped offsets read 0.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            IntcPending: rd_data[NUM_SRC-1:0] = pend;
            IntcMask:    rd_data[NUM_SRC-1:0] = mask_q;
            IntcMode:    rd_data[NUM_SRC-1:0] = mode_q;
            IntcPol:     rd_data[NUM_SRC-1:0] = pol_q;
            IntcClaim:   rd_data              = claim_val;
            IntcRaw:     rd_data[NUM_SRC-1:0] = act;
            default: ;
        endcase
    end

    assign bus.data_o = rd_en ? rd_data : '0;

endmodule
